// File: rtl/hack_pkg.sv
// Shared types, address map constants and region decode for the Hack data memory.
package hack_pkg;

    typedef logic [15:0] word_t;
    typedef logic [14:0] addr_t;

    localparam addr_t SCREEN_BASE = 15'h4000;
    localparam addr_t KBD_ADDR    = 15'h6000;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_SCREEN,
        REG_KBD,
        REG_NONE
    } region_e;

    // Bit 14 clear selects RAM; 10 selects the screen; the 11 quadrant holds
    // only the keyboard word, everything else there is unmapped.
    function automatic region_e decode(input addr_t a);
        region_e r;
        if (!a[14]) begin
            r = REG_RAM;
        end else if (!a[13]) begin
            r = REG_SCREEN;
        end else if (a == KBD_ADDR) begin
            r = REG_KBD;
        end else begin
            r = REG_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/hack_ram.sv
// Word memory: synchronous write, asynchronous read, optional registered second read port.
module hack_ram #(
    parameter int DEPTH  = 16384,
    parameter int WIDTH  = 16,
    parameter bit READ2  = 1'b0,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              we,
    output logic [WIDTH-1:0]  rdata,
    input  logic [ADDR_W-1:0] addr2,
    output logic [WIDTH-1:0]  rdata2
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

    // Second port samples the array before this edge's write lands,
    // giving read-before-write on a same-word collision.
    generate
        if (READ2) begin : g_rd2
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata2 <= '0;
                end else begin
                    rdata2 <= mem[addr2];
                end
            end
        end else begin : g_no_rd2
            assign rdata2 = '0;
        end
    endgenerate

endmodule

// File: rtl/hack_memory.sv
// Hack data memory: RAM16K, screen map with a scanner read port, and keyboard register.
module hack_memory
    import hack_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int RAM_WORDS    = 16384,
    parameter int SCREEN_WORDS = 8192
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [14:0]      address,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    output logic [WIDTH-1:0] out,
    input  logic [12:0]      scr_addr,
    output logic [WIDTH-1:0] scr_data,
    input  logic [WIDTH-1:0] kbd_code,
    input  logic             kbd_valid,
    input  logic             kbd_release
);

    region_e          region;
    logic [WIDTH-1:0] ram_rdata;
    logic [WIDTH-1:0] scr_rdata;
    logic [WIDTH-1:0] ram_rdata2;
    logic [WIDTH-1:0] kbd_reg;

    assign region = decode(address);

    hack_ram #(
        .DEPTH (RAM_WORDS),
        .WIDTH (WIDTH),
        .READ2 (1'b0)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .addr   (address[13:0]),
        .wdata  (in),
        .we     (load && (region == REG_RAM)),
        .rdata  (ram_rdata),
        .addr2  (14'd0),
        .rdata2 (ram_rdata2)
    );

    hack_ram #(
        .DEPTH (SCREEN_WORDS),
        .WIDTH (WIDTH),
        .READ2 (1'b1)
    ) u_screen (
        .clk    (clk),
        .rst    (rst),
        .addr   (address[12:0]),
        .wdata  (in),
        .we     (load && (region == REG_SCREEN)),
        .rdata  (scr_rdata),
        .addr2  (scr_addr),
        .rdata2 (scr_data)
    );

    // kbd_valid and kbd_release are single-cycle strobes sampled on the
    // rising edge with no back-pressure; a new code beats a release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kbd_reg <= '0;
        end else if (kbd_valid) begin
            kbd_reg <= kbd_code;
        end else if (kbd_release) begin
            kbd_reg <= '0;
        end
    end

    always_comb begin
        out = '0;
        case (region)
            REG_RAM:    out = ram_rdata;
            REG_SCREEN: out = scr_rdata;
            REG_KBD:    out = kbd_reg;
            default:    out = '0;
        endcase
    end

endmodule

// File: tb/tb_hack_memory.sv
// Self-checking bench for hack_memory against an address-map model built from associative arrays.
module tb_hack_memory;

    logic        clk;
    logic        rst;
    logic [14:0] address;
    logic [15:0] in;
    logic        load;
    logic [15:0] out;
    logic [12:0] scr_addr;
    logic [15:0] scr_data;
    logic [15:0] kbd_code;
    logic        kbd_valid;
    logic        kbd_release;

    int errors = 0;
    int checks = 0;

    // Reference model: only written words are known.
    logic [15:0] ram_m [int];
    logic [15:0] scr_m [int];
    logic [15:0] kbd_m;
    logic [15:0] exp_scr;
    bit          exp_scr_k;
    logic [15:0] exp_q [$];

    hack_memory #(
        .WIDTH        (16),
        .RAM_WORDS    (16384),
        .SCREEN_WORDS (8192)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .in          (in),
        .load        (load),
        .out         (out),
        .scr_addr    (scr_addr),
        .scr_data    (scr_data),
        .kbd_code    (kbd_code),
        .kbd_valid   (kbd_valid),
        .kbd_release (kbd_release)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic bit model_read(input int a, output logic [15:0] v);
        bit k;
        v = 16'h0000;
        k = 1'b1;
        if (a < 'h4000) begin
            k = ram_m.exists(a);
            if (k) v = ram_m[a];
        end else if (a < 'h6000) begin
            k = scr_m.exists(a - 'h4000);
            if (k) v = scr_m[a - 'h4000];
        end else if (a == 'h6000) begin
            v = kbd_m;
        end
        return k;
    endfunction

    // One clock edge: model next state from the current inputs, then edge.
    task automatic tick();
        logic [15:0] nscr;
        bit          nk;
        int          a;
        nk = scr_m.exists(int'(scr_addr));
        nscr = nk ? scr_m[int'(scr_addr)] : 16'h0000;
        a = int'(address);
        if (load) begin
            if (a < 'h4000) ram_m[a] = in;
            else if (a < 'h6000) scr_m[a - 'h4000] = in;
        end
        if (kbd_valid) kbd_m = kbd_code;
        else if (kbd_release) kbd_m = 16'h0000;
        @(posedge clk);
        #1;
        exp_scr   = nscr;
        exp_scr_k = nk;
        load        = 1'b0;
        kbd_valid   = 1'b0;
        kbd_release = 1'b0;
    endtask

    task automatic cpu_write(input logic [14:0] a, input logic [15:0] d);
        address = a;
        in      = d;
        load    = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        address = 15'h6000;
        #3;
        checks++;
        if (scr_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_scr_data: got %h expected 0000", scr_data);
        end
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_kbd: got %h expected 0000", out);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        kbd_m = 16'h0000;
        tick();
        address = 15'h6000;
        #1;
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL kbd_after_reset: got %h expected 0000", out);
        end
    endtask

    task automatic test_ram();
        cpu_write(15'h0000, 16'h1234);
        cpu_write(15'h3FFF, 16'hBEEF);
        address = 15'h0000;
        #1;
        checks++;
        if (out !== 16'h1234) begin
            errors++;
            $display("FAIL ram_0000: got %h expected 1234", out);
        end
        address = 15'h3FFF;
        #1;
        checks++;
        if (out !== 16'hBEEF) begin
            errors++;
            $display("FAIL ram_3fff: got %h expected beef", out);
        end
    endtask

    task automatic test_screen();
        cpu_write(15'h4000, 16'hFFFF);
        cpu_write(15'h5FFF, 16'h00F0);
        address = 15'h4000;
        #1;
        checks++;
        if (out !== 16'hFFFF) begin
            errors++;
            $display("FAIL scr_cpu_4000: got %h expected ffff", out);
        end
        address = 15'h5FFF;
        #1;
        checks++;
        if (out !== 16'h00F0) begin
            errors++;
            $display("FAIL scr_cpu_5fff: got %h expected 00f0", out);
        end
        address = 15'h3FFF;
        #1;
        checks++;
        if (out !== 16'hBEEF) begin
            errors++;
            $display("FAIL ram_3fff_alias: got %h expected beef", out);
        end
        scr_addr = 13'h0000;
        tick();
        checks++;
        if (scr_data !== 16'hFFFF) begin
            errors++;
            $display("FAIL scan_0000: got %h expected ffff", scr_data);
        end
        scr_addr = 13'h1FFF;
        tick();
        checks++;
        if (scr_data !== 16'h00F0) begin
            errors++;
            $display("FAIL scan_1fff: got %h expected 00f0", scr_data);
        end
        cpu_write(15'h4005, 16'h1357);
        scr_addr = 13'h0005;
        tick();
        checks++;
        if (scr_data !== 16'h1357) begin
            errors++;
            $display("FAIL scan_0005_pre: got %h expected 1357", scr_data);
        end
        cpu_write(15'h4005, 16'hAAAA);
        checks++;
        if (scr_data !== 16'h1357) begin
            errors++;
            $display("FAIL scan_rbw_old: got %h expected 1357", scr_data);
        end
        tick();
        checks++;
        if (scr_data !== 16'hAAAA) begin
            errors++;
            $display("FAIL scan_rbw_new: got %h expected aaaa", scr_data);
        end
    endtask

    task automatic test_reset_midop();
        kbd_code  = 16'h0041;
        kbd_valid = 1'b1;
        scr_addr  = 13'h0000;
        tick();
        address = 15'h6000;
        #1;
        checks++;
        if (out !== 16'h0041 || scr_data !== 16'hFFFF) begin
            errors++;
            $display("FAIL midop_preload: got kbd %h scr %h expected 0041 ffff", out, scr_data);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out !== 16'h0000 || scr_data !== 16'h0000) begin
            errors++;
            $display("FAIL midop_async_clear: got kbd %h scr %h expected 0000 0000", out, scr_data);
        end
        kbd_m = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        tick();
        address = 15'h0000;
        #1;
        checks++;
        if (out !== 16'h1234) begin
            errors++;
            $display("FAIL midop_ram_kept: got %h expected 1234", out);
        end
    endtask

    task automatic test_keyboard();
        kbd_code  = 16'h0083;
        kbd_valid = 1'b1;
        tick();
        address = 15'h6000;
        #1;
        checks++;
        if (out !== 16'h0083) begin
            errors++;
            $display("FAIL kbd_press: got %h expected 0083", out);
        end
        kbd_release = 1'b1;
        tick();
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL kbd_release: got %h expected 0000", out);
        end
        kbd_code    = 16'h0020;
        kbd_valid   = 1'b1;
        kbd_release = 1'b1;
        tick();
        checks++;
        if (out !== 16'h0020) begin
            errors++;
            $display("FAIL kbd_both: got %h expected 0020", out);
        end
        tick();
        checks++;
        if (out !== 16'h0020) begin
            errors++;
            $display("FAIL kbd_hold: got %h expected 0020", out);
        end
    endtask

    task automatic test_protect();
        logic [15:0] v;
        cpu_write(15'h6000, 16'h5555);
        address = 15'h6000;
        #1;
        checks++;
        if (out !== 16'h0020) begin
            errors++;
            $display("FAIL kbd_write_dropped: got %h expected 0020", out);
        end
        cpu_write(15'h7ABC, 16'h5555);
        address = 15'h7ABC;
        #1;
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL unmapped_read: got %h expected 0000", out);
        end
        foreach (exp_q[i]) exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            logic [14:0] a;
            a = (i == 0) ? 15'h0000 : (i == 1) ? 15'h3FFF : (i == 2) ? 15'h4000 : 15'h5FFF;
            void'(model_read(int'(a), v));
            address = a;
            #1;
            checks++;
            if (out !== v) begin
                errors++;
                $display("FAIL protect_unchanged[%h]: got %h expected %h", a, out, v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        for (int i = 0; i < 8; i++) begin
            cpu_write((i % 2 == 0) ? 15'h0010 : 15'h4010, 16'($urandom));
        end
        void'(model_read('h0010, v));
        exp_q.push_back(v);
        void'(model_read('h4010, v));
        exp_q.push_back(v);
        address = 15'h0010;
        #1;
        v = exp_q.pop_front();
        checks++;
        if (out !== v) begin
            errors++;
            $display("FAIL b2b_ram_0010: got %h expected %h", out, v);
        end
        address = 15'h4010;
        #1;
        v = exp_q.pop_front();
        checks++;
        if (out !== v) begin
            errors++;
            $display("FAIL b2b_scr_4010: got %h expected %h", out, v);
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        logic [14:0] a;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 4))
                0: a = 15'($urandom_range(0, 15));
                1: a = 15'($urandom_range('h3FF8, 'h3FFF));
                2: a = 15'($urandom_range('h4000, 'h400F));
                3: a = 15'($urandom_range('h5FF8, 'h5FFF));
                default: a = 15'($urandom_range('h6000, 'h7FFF));
            endcase
            address     = a;
            in          = 16'($urandom);
            load        = ($urandom_range(0, 1) == 1);
            kbd_code    = 16'($urandom);
            kbd_valid   = ($urandom_range(0, 5) == 0);
            kbd_release = ($urandom_range(0, 5) == 0);
            scr_addr    = ($urandom_range(0, 1) == 1) ? 13'($urandom_range(0, 15))
                                                      : 13'($urandom_range('h1FF8, 'h1FFF));
            tick();
            if (exp_scr_k) begin
                checks++;
                if (scr_data !== exp_scr) begin
                    errors++;
                    $display("FAIL rand_scan[%0d] addr %h: got %h expected %h", n, scr_addr, scr_data, exp_scr);
                end
            end
            a = ($urandom_range(0, 3) == 0) ? 15'h6000 : 15'($urandom_range(0, 'h7FFF) & 'h600F);
            address = a;
            #1;
            if (model_read(int'(a), v)) begin
                checks++;
                if (out !== v) begin
                    errors++;
                    $display("FAIL rand_read[%0d] addr %h: got %h expected %h", n, a, out, v);
                end
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        address     = 15'h6000;
        in          = 16'h0000;
        load        = 1'b0;
        scr_addr    = 13'h0000;
        kbd_code    = 16'h0000;
        kbd_valid   = 1'b0;
        kbd_release = 1'b0;
        kbd_m       = 16'h0000;
        exp_scr     = 16'h0000;
        exp_scr_k   = 1'b0;
        test_reset();
        test_ram();
        test_screen();
        test_reset_midop();
        test_keyboard();
        test_protect();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
